// File: rtl/nios2_ocimem_pkg.sv
// Shared types for the OCI memory command sequencer: command encoding, jdo field positions, FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a.
package nios2_ocimem_pkg;

    // jdo field positions. The address field starts at JDO_ADDR_LSB and is ADDR_W wide.
    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 26;

    // Widest address that fits between the address LSB and the rd flag.
    localparam int CMD_ADDR_W = JDO_RD_BIT - JDO_ADDR_LSB;

    typedef enum logic [1:0] {
        CMD_SETADDR = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_READ    = 2'd2
    } cmd_kind_t;

    typedef struct packed {
        cmd_kind_t             kind;
        logic [CMD_ADDR_W-1:0] addr;
        logic                  rd;
        logic [31:0]           data;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_ISSUE_RD = 3'd2,
        ST_ISSUE_WR = 3'd3,
        ST_WAIT_RD  = 3'd4
    } state_t;

endpackage

// File: rtl/nios2_ocimem_cmd_fifo.sv
// Command queue between strobe decode and the access FSM.
// Latency: a pushed entry is visible at the head one cycle later; no same-cycle bypass.
// Backpressure: full blocks pushes, empty blocks pops; both are ignored rather than corrupting state.
module nios2_ocimem_cmd_fifo
    import nios2_ocimem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_dat,
    input  logic pop,
    output cmd_t pop_dat,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    cmd_t       store [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = store[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards all queued commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) store[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/nios2_ocimem_cmd_sequencer.sv
// Turns JTAG debug strobes + jdo into queued, ordered OCI memory accesses; owns the monitor address.
// Latency: strobe to request 3 cycles; zero-wait write 3 cycles, read 3+READ_LATENCY cycles per command.
// Backpressure: waitrequest holds the request (aborted after TIMEOUT stalls); full queue drops strobes with cmd_drop.
module nios2_ocimem_cmd_sequencer
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              cmd_drop
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam int LAT_W   = $clog2(READ_LATENCY + 2);

    localparam logic [ADDR_W-1:0]  ADDR_ONE   = 1;
    localparam logic [STALL_W-1:0] STALL_ONE  = 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0]   LAT_ONE    = 1;
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY);

    state_t             state;
    cmd_t               cur;
    cmd_t               push_cmd;
    cmd_t               head;
    logic               push_req;
    logic               push_acc;
    logic               drop;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               stall_hit;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        wdata;
    logic [31:0]        mon;
    logic               err_q;
    logic               ready_q;
    logic               drop_q;
    logic [STALL_W-1:0] stall_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               jdo_unused;

    // jdo bits outside every command field.
    assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

    // Strobe decode: one command per cycle, a > b > no_action; losers and full-queue strobes are dropped.
    always_comb begin
        push_req = 1'b0;
        drop     = 1'b0;
        push_cmd = '0;
        if (take_action_ocimem_a) begin
            push_req      = 1'b1;
            push_cmd.kind = CMD_SETADDR;
            push_cmd.addr = CMD_ADDR_W'(jdo[JDO_ADDR_LSB +: ADDR_W]);
            push_cmd.rd   = jdo[JDO_RD_BIT];
            drop          = take_action_ocimem_b | take_no_action_ocimem_a;
        end else if (take_action_ocimem_b) begin
            push_req      = 1'b1;
            push_cmd.kind = CMD_WRITE;
            push_cmd.data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            drop          = take_no_action_ocimem_a;
        end else if (take_no_action_ocimem_a) begin
            push_req      = 1'b1;
            push_cmd.kind = CMD_READ;
        end
        // Full is judged on the pre-pop count, so a pop this cycle does not make room.
        push_acc = push_req && !fifo_full;
        if (push_req && fifo_full) drop = 1'b1;
    end

    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign stall_hit = ((state == ST_ISSUE_RD) || (state == ST_ISSUE_WR)) &&
                       mem_waitrequest && (stall_cnt == STALL_LAST);

    nios2_ocimem_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_acc),
        .push_dat (push_cmd),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Access FSM plus the status registers it owns (address, read data, error, ready, drop pulse).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            addr      <= '0;
            wdata     <= '0;
            mon       <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            drop_q    <= 1'b0;
            stall_cnt <= '0;
            lat_cnt   <= '0;
        end else begin
            drop_q <= drop;

            if (push_acc) begin
                ready_q <= 1'b0;
            end else if ((state == ST_IDLE) && fifo_empty) begin
                ready_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    stall_cnt <= '0;
                    case (cur.kind)
                        CMD_SETADDR: begin
                            addr  <= ADDR_W'(cur.addr);
                            err_q <= 1'b0;
                            state <= cur.rd ? ST_ISSUE_RD : ST_IDLE;
                        end
                        CMD_WRITE: begin
                            wdata <= cur.data;
                            state <= ST_ISSUE_WR;
                        end
                        CMD_READ: state <= ST_ISSUE_RD;
                        default:  state <= ST_IDLE;
                    endcase
                end
                ST_ISSUE_WR: begin
                    if (!mem_waitrequest) begin
                        addr  <= addr + ADDR_ONE;
                        state <= ST_IDLE;
                    end else if (stall_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_ONE;
                    end
                end
                ST_ISSUE_RD: begin
                    if (!mem_waitrequest) begin
                        if (READ_LATENCY == 0) begin
                            mon   <= mem_readdata;
                            addr  <= addr + ADDR_ONE;
                            state <= ST_IDLE;
                        end else begin
                            lat_cnt <= LAT_ONE;
                            state   <= ST_WAIT_RD;
                        end
                    end else if (stall_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_ONE;
                    end
                end
                ST_WAIT_RD: begin
                    if (lat_cnt == LAT_LAST) begin
                        mon   <= mem_readdata;
                        addr  <= addr + ADDR_ONE;
                        state <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Error setting wins over a SETADDR clear in the same cycle.
            if (drop || stall_hit) err_q <= 1'b1;
        end
    end

    assign mem_address   = addr;
    assign mem_read      = (state == ST_ISSUE_RD);
    assign mem_write     = (state == ST_ISSUE_WR);
    assign mem_writedata = wdata;
    assign MonDReg       = mon;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
    assign cmd_drop      = drop_q;

endmodule

// File: tb/tb_nios2_ocimem_cmd_sequencer.sv
// Directed bench for the OCI command sequencer with a one-cycle-latency memory model.
// Latency: n/a.
// Backpressure: waitrequest is driven per scenario.
module tb_nios2_ocimem_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a;
    logic        take_b;
    logic        take_r;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        cmd_drop;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          drop_cnt = 0;
    logic [31:0] rd_value;
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  rd_addr_q[$];

    nios2_ocimem_cmd_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_r),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_waitrequest         (mem_waitrequest),
        .mem_readdata            (mem_readdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cmd_drop                (cmd_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: logs accepted accesses; read data is valid only one cycle after acceptance.
    always @(posedge clk) begin
        if (!reset && mem_write && !mem_waitrequest) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_writedata);
        end
        if (!reset && mem_read && !mem_waitrequest) begin
            rd_addr_q.push_back(mem_address);
            mem_readdata <= rd_value;
        end else begin
            mem_readdata <= 32'hBAD0BAD0;
        end
    end

    // Counts cycles with cmd_drop high.
    always @(negedge clk) begin
        if (cmd_drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
        $fatal(1);
    end

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[33:26] = a;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe_a(input logic [7:0] a, input logic rd);
        take_a = 1'b1; jdo = jdo_a(a, rd);
        @(negedge clk);
        take_a = 1'b0; jdo = '0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        take_b = 1'b1; jdo = jdo_b(d);
        @(negedge clk);
        take_b = 1'b0; jdo = '0;
    endtask

    task automatic strobe_r();
        take_r = 1'b1;
        @(negedge clk);
        take_r = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int c;
        c = 0;
        while (monitor_ready !== 1'b1 && c < limit) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b, want 0", mem_read); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b, want 0", mem_write); end
        n_checks++; if (mem_address !== 8'h00) begin n_fail++; $display("FAIL reset_mem_address: got %h, want 00", mem_address); end
        n_checks++; if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata: got %h, want 0", mem_writedata); end
        n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_MonDReg: got %h, want 0", MonDReg); end
        n_checks++; if (monitor_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, want 1", monitor_ready); end
        n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b, want 0", monitor_error); end
        n_checks++; if (cmd_drop !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_drop: got %b, want 0", cmd_drop); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_setaddr_read();
        int c;
        int n;
        logic [7:0] la;
        mem_waitrequest = 1'b0;
        rd_value = 32'hCAFE0001;
        strobe_a(8'h10, 1'b1);
        n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_drop: got %b, want 0", monitor_ready); end
        c = 0;
        while (mem_read !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        n_checks++; if (c != 2) begin n_fail++; $display("FAIL rd_issue_latency: got %0d, want 2", c); end
        n_checks++; if (mem_address !== 8'h10) begin n_fail++; $display("FAIL rd_address: got %h, want 10", mem_address); end
        wait_ready(20);
        n_checks++; if (monitor_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_return: got %b, want 1", monitor_ready); end
        n_checks++; if (MonDReg !== 32'hCAFE0001) begin n_fail++; $display("FAIL rd_MonDReg: got %h, want cafe0001", MonDReg); end
        rd_value = 32'h12345678;
        n = rd_addr_q.size();
        strobe_r();
        wait_ready(20);
        la = (rd_addr_q.size() > n) ? rd_addr_q[n] : 8'hxx;
        n_checks++; if (la !== 8'h11) begin n_fail++; $display("FAIL rd_next_address: got %h, want 11", la); end
        n_checks++; if (MonDReg !== 32'h12345678) begin n_fail++; $display("FAIL rd_next_data: got %h, want 12345678", MonDReg); end
    endtask

    task automatic test_write_wrap();
        int n;
        int c;
        n = wr_addr_q.size();
        mem_waitrequest = 1'b1;
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'h11111111);
        strobe_b(32'h22222222);
        c = 0;
        while (mem_write !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        n_checks++; if (mem_address !== 8'hFF || mem_writedata !== 32'h11111111) begin
            n_fail++; $display("FAIL wr_first_issue: got %h/%h, want ff/11111111", mem_address, mem_writedata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'hFF || mem_writedata !== 32'h11111111) begin
                n_fail++; $display("FAIL wr_stall_hold[%0d]: got %b %h/%h, want 1 ff/11111111", i, mem_write, mem_address, mem_writedata); end
        end
        mem_waitrequest = 1'b0;
        wait_ready(30);
        n_checks++; if (wr_addr_q.size() != n + 2) begin n_fail++; $display("FAIL wr_count: got %0d, want 2", wr_addr_q.size() - n); end
        if (wr_addr_q.size() == n + 2) begin
            n_checks++; if (wr_addr_q[n] !== 8'hFF || wr_data_q[n] !== 32'h11111111) begin
                n_fail++; $display("FAIL wr_first_land: got %h/%h, want ff/11111111", wr_addr_q[n], wr_data_q[n]); end
            n_checks++; if (wr_addr_q[n+1] !== 8'h00 || wr_data_q[n+1] !== 32'h22222222) begin
                n_fail++; $display("FAIL wr_wrap_land: got %h/%h, want 00/22222222", wr_addr_q[n+1], wr_data_q[n+1]); end
        end
    endtask

    task automatic test_overflow();
        int n;
        int d;
        int c;
        n = wr_addr_q.size();
        d = drop_cnt;
        mem_waitrequest = 1'b1;
        strobe_b(32'hA0A0A0A0);
        c = 0;
        while (mem_write !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        for (int i = 0; i < 6; i++) begin
            take_b = 1'b1;
            jdo = jdo_b(32'hB0000000 + i);
            @(negedge clk);
        end
        take_b = 1'b0;
        jdo = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (drop_cnt - d != 2) begin n_fail++; $display("FAIL ovf_drop_pulses: got %0d, want 2", drop_cnt - d); end
        n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b, want 1", monitor_error); end
        mem_waitrequest = 1'b0;
        wait_ready(60);
        n_checks++; if (wr_addr_q.size() != n + 5) begin n_fail++; $display("FAIL ovf_accepted: got %0d, want 5", wr_addr_q.size() - n); end
        n_checks++; if (wr_data_q.size() == 0 || wr_data_q[wr_data_q.size()-1] !== 32'hB0000003) begin
            n_fail++; $display("FAIL ovf_last_data: want b0000003"); end
    endtask

    task automatic test_timeout();
        int n;
        int c;
        mem_waitrequest = 1'b0;
        strobe_a(8'h40, 1'b0);
        wait_ready(20);
        n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL to_setaddr_clear: got %b, want 0", monitor_error); end
        n = rd_addr_q.size();
        mem_waitrequest = 1'b1;
        strobe_r();
        c = 0;
        while (mem_read !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        c = 0;
        while (mem_read === 1'b1 && c < 400) begin @(negedge clk); c++; end
        n_checks++; if (c != 255) begin n_fail++; $display("FAIL to_read_cycles: got %0d, want 255", c); end
        wait_ready(20);
        n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL to_error: got %b, want 1", monitor_error); end
        n_checks++; if (mem_address !== 8'h40) begin n_fail++; $display("FAIL to_addr_kept: got %h, want 40", mem_address); end
        n_checks++; if (rd_addr_q.size() != n) begin n_fail++; $display("FAIL to_no_accept: got %0d reads, want 0", rd_addr_q.size() - n); end
        mem_waitrequest = 1'b0;
        strobe_a(8'h41, 1'b0);
        wait_ready(20);
        n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL to_error_cleared: got %b, want 0", monitor_error); end
        n_checks++; if (mem_address !== 8'h41) begin n_fail++; $display("FAIL to_new_addr: got %h, want 41", mem_address); end
    endtask

    task automatic test_simultaneous();
        int n;
        int d;
        int r;
        logic [7:0] la;
        mem_waitrequest = 1'b0;
        n = wr_addr_q.size();
        d = drop_cnt;
        take_a = 1'b1;
        take_b = 1'b1;
        jdo = jdo_a(8'h20, 1'b0);
        @(negedge clk);
        take_a = 1'b0;
        take_b = 1'b0;
        jdo = '0;
        wait_ready(20);
        repeat (2) @(negedge clk);
        n_checks++; if (drop_cnt - d != 1) begin n_fail++; $display("FAIL sim_drop_cycles: got %0d, want 1", drop_cnt - d); end
        n_checks++; if (wr_addr_q.size() != n) begin n_fail++; $display("FAIL sim_no_write: got %0d writes, want 0", wr_addr_q.size() - n); end
        n_checks++; if (mem_address !== 8'h20) begin n_fail++; $display("FAIL sim_setaddr: got %h, want 20", mem_address); end
        rd_value = 32'h0D15EA5E;
        r = rd_addr_q.size();
        strobe_r();
        wait_ready(20);
        la = (rd_addr_q.size() > r) ? rd_addr_q[r] : 8'hxx;
        n_checks++; if (la !== 8'h20 || MonDReg !== 32'h0D15EA5E) begin
            n_fail++; $display("FAIL sim_read_after: got %h/%h, want 20/0d15ea5e", la, MonDReg); end
    endtask

    task automatic test_reset_mid_read();
        int c;
        int n;
        mem_waitrequest = 1'b0;
        rd_value = 32'h55AA55AA;
        strobe_a(8'h30, 1'b1);
        strobe_r();
        c = 0;
        while (mem_read !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        n_checks++; if (mem_address !== 8'h30) begin n_fail++; $display("FAIL rst_pre_addr: got %h, want 30", mem_address); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b%b, want 00", mem_read, mem_write); end
        n_checks++; if (mem_address !== 8'h00 || mem_writedata !== 32'h0) begin
            n_fail++; $display("FAIL rst_addr_data: got %h/%h, want 00/0", mem_address, mem_writedata); end
        n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_MonDReg: got %h, want 0", MonDReg); end
        n_checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0 || cmd_drop !== 1'b0) begin
            n_fail++; $display("FAIL rst_status: got rdy=%b err=%b drop=%b, want 1 0 0", monitor_ready, monitor_error, cmd_drop); end
        reset = 1'b0;
        n = rd_addr_q.size();
        repeat (6) @(negedge clk);
        n_checks++; if (rd_addr_q.size() != n || mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_empty: queued read still issued"); end
        n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_late_data: got %h, want 0", MonDReg); end
        n_checks++; if (monitor_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_hold: got %b, want 1", monitor_ready); end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_a = 1'b0;
        take_b = 1'b0;
        take_r = 1'b0;
        mem_waitrequest = 1'b0;
        rd_value = 32'h0;
        @(negedge clk);
        test_reset();
        test_setaddr_read();
        test_write_wrap();
        test_overflow();
        test_timeout();
        test_simultaneous();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_ocimem_cmd_sequencer.md
Name: nios2_ocimem_cmd_sequencer

Overview:
System-clock-side controller that turns the JTAG debug module's per-cycle action strobes and 38-bit jdo word into ordered on-chip-memory (OCI) accesses.
- Queues decoded commands in a small FIFO and runs them one at a time on a waitrequest-style memory port.
- Owns the auto-incrementing monitor address.
- Returns MonDReg, monitor_ready and monitor_error to the JTAG tck-side logic.
- Sits between the debug-module sysclk logic and the debug ROM/RAM slave.

Parameters:
ADDR_W, 8, word-address width of the OCI memory; address wraps modulo 2^ADDR_W.
FIFO_DEPTH, 4, command queue entries; must be a power of 2, at least 2.
READ_LATENCY, 1, cycles from an accepted read (read high, waitrequest low) to valid mem_readdata.
TIMEOUT, 255, maximum consecutive waitrequest cycles before the access is aborted.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
jdo  in  38  JTAG data-out word, valid in the cycle of any strobe.
take_action_ocimem_a  in  1  strobe: set address; optionally start a read.
take_action_ocimem_b  in  1  strobe: write data at the current address.
take_no_action_ocimem_a  in  1  strobe: read at the current address.
mem_address  out  ADDR_W  word address.
mem_read  out  1  read request.
mem_write  out  1  write request.
mem_writedata  out  32  write data.
mem_waitrequest  in  1  slave stall; holds the request.
mem_readdata  in  32  read data, valid READ_LATENCY cycles after acceptance.
MonDReg  out  32  last read data.
monitor_ready  out  1  high when the queue is empty and the FSM is idle.
monitor_error  out  1  sticky error: timeout or dropped command.
cmd_drop  out  1  one-cycle pulse when a strobe is discarded.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, MonDReg=0, monitor_ready=1, monitor_error=0, cmd_drop=0. Reset also empties the FIFO and sets state IDLE.
- Reset mid-access: the request drops on that same edge; no readdata is captured afterwards.

Command decode (at the strobe cycle):
- ocimem_a pushes SETADDR {addr=jdo[ADDR_W+25:26], rd=jdo[35]}.
- ocimem_b pushes WRITE {data=jdo[34:3]}.
- no_action_ocimem_a pushes READ.
- Simultaneous strobes: priority ocimem_a > ocimem_b > no_action. Each lower-priority strobe is discarded; cmd_drop pulses and monitor_error is set.
- FIFO full at a strobe: the strobe is discarded; cmd_drop pulses and monitor_error is set.
- A push and a pop in the same cycle when full is not permitted; the full test uses the pre-pop count.

Address and status rules:
- The address register updates at execution time, never at enqueue.
- After WRITE or READ completes: addr <= addr+1, wrapping to 0 after 2^ADDR_W-1.
- monitor_ready drops the cycle after any accepted push. It rises the cycle after the FSM returns to IDLE with the FIFO empty.
- SETADDR clears monitor_error when it executes.

FSM:
- IDLE: if the FIFO is non-empty, pop -> EXEC.
- EXEC, SETADDR: addr <= entry.addr; if rd, go to ISSUE_RD, else go to IDLE.
- EXEC, WRITE: go to ISSUE_WR.
- EXEC, READ: go to ISSUE_RD.
- ISSUE_RD / ISSUE_WR: drive mem_read or mem_write with mem_address=addr.
  - Hold until waitrequest=0; acceptance is the cycle the request is high and waitrequest is low.
  - Write accepted: addr++ -> IDLE.
  - Read accepted: go to WAIT_RD with a latency counter.
- Timeout: a stall counter counts waitrequest cycles. On the TIMEOUT-th cycle, deassert the request, set monitor_error, leave addr unchanged, go to IDLE.
- WAIT_RD: after READ_LATENCY cycles, MonDReg <= mem_readdata, addr++ -> IDLE.
  - READ_LATENCY=0: capture in the acceptance cycle; skip WAIT_RD.
- Throughput: minimum 3 cycles per zero-wait write; 3+READ_LATENCY per read.

Decomposition:
- Shared package nios2_ocimem_pkg holds:
  - the cmd_kind enum (SETADDR, WRITE, READ);
  - the cmd_t struct {kind, addr, rd, data};
  - the jdo field bit-position constants;
  - the FSM state enum.
- One sub-module, nios2_ocimem_cmd_fifo: synchronous FIFO with push/pop/full/empty, depth FIFO_DEPTH, cmd_t entries, no same-cycle bypass.

Test Plan:
1. Address-set with read:
   - Stimulus: ocimem_a, jdo[33:26]=8'h10, jdo[35]=1; memory returns 32'hCAFE0001.
   - Required: mem_read observed at address 0x10; MonDReg=32'hCAFE0001; monitor_ready returns to 1; next READ is issued at 0x11.
2. Writes with stall and wrap:
   - Stimulus: SETADDR 0xFF, then two ocimem_b writes (0x11111111, 0x22222222); waitrequest held 3 cycles on the first.
   - Required: writes land at 0xFF then 0x00; mem_write is held stable through the stall.
3. Overflow:
   - Stimulus: 6 back-to-back ocimem_b strobes while waitrequest=1.
   - Required: 4 strobes accepted; cmd_drop pulses twice; monitor_error=1.
4. Timeout:
   - Stimulus: waitrequest tied high on a read.
   - Required: mem_read deasserts after 255 cycles; monitor_error=1; address unchanged; a following SETADDR clears the error.
5. Simultaneous strobes:
   - Stimulus: ocimem_a and ocimem_b in the same cycle.
   - Required: only SETADDR is queued; cmd_drop=1 for one cycle.
6. Reset mid-read:
   - Stimulus: assert reset during WAIT_RD.
   - Required: next cycle all outputs equal reset values; a late mem_readdata is ignored; the FIFO is empty.
